// File: rtl/cache_fill_fsm_pkg.sv
// cache_fill_fsm shared definitions
// block geometry, counter width and FSM state encoding
package cache_fill_fsm_pkg;

  localparam int WORDS_PER_BLOCK   = 8;
  localparam int ADDR_W            = 16;
  localparam int DATA_W            = 16;
  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int WORD_IDX_BITS     = 3;
  localparam int CNT_W             = WORD_IDX_BITS + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

endpackage

// File: rtl/cache_fill_fsm_if.sv
// cache_fill_fsm bus bundle
// CPU miss side, memory side and cache array side
interface cache_fill_fsm_if;
  import cache_fill_fsm_pkg::*;

  logic                     miss_detected;
  logic [ADDR_W-1:0]        miss_address;
  logic [DATA_W-1:0]        memory_data;
  logic                     memory_data_valid;
  logic                     fsm_busy;
  logic                     memory_read;
  logic [ADDR_W-1:0]        memory_address;
  logic                     write_data_array;
  logic [WORD_IDX_BITS-1:0] fill_word;
  logic [DATA_W-1:0]        fill_data;
  logic                     write_tag_array;

  modport slave (
    input  miss_detected, miss_address,
    input  memory_data, memory_data_valid,
    output fsm_busy, memory_read, memory_address,
    output write_data_array, fill_word, fill_data,
    output write_tag_array
  );

  modport master (
    output miss_detected, miss_address,
    output memory_data, memory_data_valid,
    input  fsm_busy, memory_read, memory_address,
    input  write_data_array, fill_word, fill_data,
    input  write_tag_array
  );

endinterface

// File: rtl/cache_fill_fsm_fill_counter.sv
// fill_counter: small up-counter
// sync reset, clear has priority over enable
module fill_counter
  import cache_fill_fsm_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // next count: clear, increment or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  // count register
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss-driven block fill controller
// issues 8 word reads, streams returns into the data array
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
(
  input logic               clk,
  input logic               rst,
  cache_fill_fsm_if.slave   bus
);

  localparam logic [CNT_W-1:0] LAST_WORD =
    CNT_W'(WORDS_PER_BLOCK - 1);

  logic [0:0]               state_q, state_d;
  logic [ADDR_W-1:0]        base_q, base_d;
  logic [CNT_W-1:0]         issue_cnt, recv_cnt;
  logic [WORD_IDX_BITS-1:0] issue_idx;
  logic                     in_fill, start;
  logic                     issue_en, recv_en, last_word;

  // all outputs are forced low while rst is asserted
  assign in_fill = (state_q == S_FILL) && !rst;
  assign start   = (state_q == S_IDLE) && !rst &&
                   bus.miss_detected;

  assign issue_en  = in_fill && !issue_cnt[CNT_W-1];
  assign recv_en   = in_fill && bus.memory_data_valid &&
                     !recv_cnt[CNT_W-1];
  assign last_word = recv_en && (recv_cnt == LAST_WORD);

  // once all requests are out, keep pointing at the last word
  assign issue_idx = issue_cnt[CNT_W-1] ?
                     '1 : issue_cnt[WORD_IDX_BITS-1:0];

  fill_counter u_issue_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (start),
    .en_i  (issue_en),
    .cnt_o (issue_cnt)
  );

  fill_counter u_recv_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (start),
    .en_i  (recv_en),
    .cnt_o (recv_cnt)
  );

  // FSM next state and block base capture
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.miss_detected) begin
          state_d = S_FILL;
          base_d  = {bus.miss_address[ADDR_W-1:BLOCK_OFFSET_BITS],
                     {BLOCK_OFFSET_BITS{1'b0}}};
        end
      end
      S_FILL: begin
        if (last_word) state_d = S_IDLE;
      end
    endcase
  end

  // state and base registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  // base has a zero offset field, so OR never carries
  assign bus.fsm_busy         = start || in_fill;
  assign bus.memory_read      = issue_en;
  assign bus.memory_address   = in_fill ?
    (base_q | ADDR_W'({issue_idx, 1'b0})) : '0;
  assign bus.write_data_array = recv_en;
  assign bus.fill_word        = recv_en ?
    recv_cnt[WORD_IDX_BITS-1:0] : '0;
  assign bus.fill_data        = recv_en ? bus.memory_data : '0;
  assign bus.write_tag_array  = last_word;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: randomized self-checking bench
// memory responder plus per-fill transaction model
module tb_cache_fill_fsm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_fill_fsm_if bus ();

  cache_fill_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] rq_addr[$];
  int          rq_due[$];
  bit          pat[$];
  int          pidx;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag, input bit all);
    check({tag, "_busy"}, bus.fsm_busy, 0);
    check({tag, "_rd"}, bus.memory_read, 0);
    check({tag, "_wr"}, bus.write_data_array, 0);
    check({tag, "_tag"}, bus.write_tag_array, 0);
    if (all) begin
      check({tag, "_addr"}, bus.memory_address, 0);
      check({tag, "_word"}, bus.fill_word, 0);
      check({tag, "_data"}, bus.fill_data, 0);
    end
  endtask

  // one whole fill: miss cycle 0, then requests/returns
  // lat: cycles from request to earliest return
  // gap_pct: chance a ready word is withheld a cycle
  // abort_after: stop the fill after this many words
  task automatic fill(input logic [15:0] addr,
                      input int lat,
                      input int gap_pct,
                      input bit use_pat,
                      input int abort_after);
    logic [15:0] base, d, ea;
    bit v, done;
    int k, issued, recvd, tag_cyc;
    base = addr & 16'hFFF0;
    pidx = 0;
    bus.miss_detected     = 1'b1;
    bus.miss_address      = addr;
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = 16'($urandom);
    @(negedge clk);
    check("miss_busy", bus.fsm_busy, 1);
    check("miss_rd", bus.memory_read, 0);
    check("miss_wr", bus.write_data_array, 0);
    step();
    k = 1; issued = 0; recvd = 0;
    done = 0; tag_cyc = -1;
    while (!done && k < 100) begin
      if (abort_after > 0 && recvd == abort_after) break;
      bus.miss_address = 16'($urandom);
      v = 0;
      d = 16'($urandom);
      if (rq_due.size() > 0 && rq_due[0] <= k) begin
        if (use_pat) begin
          v = (pidx < pat.size()) ? pat[pidx] : 1'b1;
          pidx++;
        end else begin
          v = ($urandom_range(99) >= gap_pct);
        end
        if (v) begin
          d = rq_addr.pop_front() ^ 16'hA5A5;
          void'(rq_due.pop_front());
        end
      end
      bus.memory_data_valid = v;
      bus.memory_data       = d;
      @(negedge clk);
      check("fill_busy", bus.fsm_busy, 1);
      check("fill_rd", bus.memory_read, issued < 8);
      if (issued < 8) begin
        ea = base + 16'(2 * issued);
        check("fill_addr", bus.memory_address, ea);
        rq_addr.push_back(ea);
        rq_due.push_back(k + lat);
        issued++;
      end
      check("fill_wr", bus.write_data_array, v);
      if (v) begin
        check("fill_word", bus.fill_word, recvd);
        check("fill_data", bus.fill_data, d);
      end
      check("fill_tag", bus.write_tag_array,
            v && recvd == 7);
      if (v) recvd++;
      if (recvd == 8) begin
        done = 1;
        tag_cyc = k;
      end
      step();
      k++;
    end
    if (abort_after == 0) begin
      check("fill_done", done, 1);
      if (gap_pct == 0 && !use_pat)
        check("tag_cycle", tag_cyc, 8 + lat);
    end
  endtask

  task automatic idle_cycle();
    bus.miss_detected     = 1'b0;
    bus.memory_data_valid = 1'b0;
    @(negedge clk);
    check_quiet("idle", 0);
    step();
  endtask

  initial begin
    pat = '{1, 0, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1};
    rst = 1'b1;
    bus.miss_detected     = 1'b0;
    bus.miss_address      = 16'h0;
    bus.memory_data       = 16'h0;
    bus.memory_data_valid = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_quiet("rst", 1);
      step();
    end
    rst = 1'b0;
    @(negedge clk);
    check_quiet("post_rst", 1);
    step();

    // directed single miss, latency 3
    fill(16'h1236, 3, 0, 0, 0);
    idle_cycle();

    // gapped returns
    fill(16'h4410, 1, 0, 1, 0);
    idle_cycle();

    // reset after three words, stray data afterwards
    fill(16'h5552, 2, 0, 0, 3);
    rst = 1'b1;
    bus.miss_detected     = 1'b0;
    bus.memory_data_valid = 1'b1;
    bus.memory_data       = 16'hBEEF;
    @(negedge clk);
    check_quiet("abort_rst", 1);
    step();
    rst = 1'b0;
    rq_addr.delete();
    rq_due.delete();
    for (int i = 0; i < 3; i++) begin
      bus.memory_data_valid = 1'b1;
      bus.memory_data       = 16'($urandom);
      @(negedge clk);
      check_quiet("stray", 1);
      step();
    end
    fill(16'h0040, 3, 0, 0, 0);
    idle_cycle();

    // back-to-back misses
    fill(16'h2000, 2, 0, 0, 0);
    fill(16'h3008, 4, 0, 0, 0);
    idle_cycle();

    // top of memory
    fill(16'hFFFE, 3, 0, 0, 0);
    idle_cycle();

    // random fills
    for (int r = 0; r < 25; r++) begin
      fill(16'($urandom), $urandom_range(1, 6),
           $urandom_range(0, 50), 0, 0);
      if ($urandom_range(3) != 0) begin
        for (int j = 0; j < int'($urandom_range(1, 3)); j++)
          idle_cycle();
      end
    end
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
